vending_machine_param: RTL

Parametrised vending controller: the next generation of the team's fixed-price coin machine. It adds configurable price and coin values, a cancel/refund path, a credit readout, and serial change dispensing over a valid/ready handshake. It sits between the coin acceptor front end (one-hot coin codes, one per cycle) and the product and coin-return actuators.

---
 rtl/vending_pkg.sv | 25 ++
 rtl/vm_change_unit.sv | 61 ++++++
 rtl/vending_machine_param.sv | 115 +++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the parametrised vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_A_CODE = 2'b01;
  localparam logic [1:0] COIN_B_CODE = 2'b10;
  localparam logic [1:0] COIN_INV    = 2'b11;

  // Credit value of a coin code; none and invalid codes are worth nothing.
  function automatic int coin_value(input logic [1:0] code, input int a_val, input int b_val);
    case (code)
      COIN_A_CODE: return a_val;
      COIN_B_CODE: return b_val;
      default:     return 0;
    endcase
  endfunction

endpackage

// File: rtl/vm_change_unit.sv
// Serial change dispenser: greedy coin selection over a valid/ready handshake.
// The owner keeps the credit register; this unit only decides which coin to
// offer next and tells the owner when a coin was taken and when it was the last.
module vm_change_unit
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 4,
  parameter int COIN_A   = 1,
  parameter int COIN_B   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CREDIT_W-1:0] start_amt,
  input  logic [CREDIT_W-1:0] remain,
  input  logic                change_rdy,
  output logic                change_vld,
  output logic [1:0]          change,
  output logic                fire,
  output logic [CREDIT_W-1:0] coin_val,
  output logic                done
);

  localparam logic [CREDIT_W-1:0] COIN_A_C = CREDIT_W'(COIN_A);
  localparam logic [CREDIT_W-1:0] COIN_B_C = CREDIT_W'(COIN_B);

  // Largest coin that still fits in the amount left to return.
  function automatic logic [1:0] pick(input logic [CREDIT_W-1:0] amt);
    return (amt >= COIN_B_C) ? COIN_B_CODE : COIN_A_CODE;
  endfunction

  logic [CREDIT_W-1:0] left_after;

  // Handshake decode: value of the offered coin and what is left once taken.
  always_comb begin
    // NOTE: every signal driven here is assigned on every path, so no latch can be inferred.
    fire       = change_vld && change_rdy;
    coin_val   = (change == COIN_B_CODE) ? COIN_B_C : COIN_A_C;
    left_after = remain - coin_val;
    done       = fire && (left_after == '0);
  end

  // Offer register: load on start, advance on each handshake, hold while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      change_vld <= 1'b0;
      change     <= COIN_NONE;
    end else if (start) begin
      change_vld <= 1'b1;
      change     <= pick(start_amt);
    end else if (fire) begin
      if (left_after == '0) begin
        change_vld <= 1'b0;
        change     <= COIN_NONE;
      end else begin
        change     <= pick(left_after);
      end
    end
  end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: coin collection, vend pulse, cancel/refund
// and serial change dispensing. FSM, credit register and coin rejection live
// here; coin selection and the return handshake live in vm_change_unit.
module vending_machine_param
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 4,
  parameter int PRICE    = 3,
  parameter int COIN_A   = 1,
  parameter int COIN_B   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in,
  input  logic                cancel,
  input  logic                change_rdy,
  output logic                out,
  output logic                change_vld,
  output logic [1:0]          change,
  output logic                coin_rej,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state;
  logic                coin_valid;
  logic                cancel_ok;
  logic                rej_next;
  logic                chg_start;
  logic                chg_fire;
  logic                chg_done;
  logic [CREDIT_W-1:0] coin_amt;
  logic [CREDIT_W-1:0] sum;
  logic [CREDIT_W-1:0] remainder;
  logic [CREDIT_W-1:0] chg_amt;
  logic [CREDIT_W-1:0] chg_coin_val;

  // Coin decode and accept/refuse decisions for the current cycle.
  always_comb begin
    coin_valid = (in == COIN_A_CODE) || (in == COIN_B_CODE);
    coin_amt   = CREDIT_W'(coin_value(in, COIN_A, COIN_B));
    sum        = credit + coin_amt;
    remainder  = credit - PRICE_C;
    // COLLECT always holds credit, but the guard keeps a zero refund impossible.
    cancel_ok  = (state == COLLECT) && cancel && (credit != '0);
    // A cancel that is accepted wins over a coin arriving in the same cycle.
    rej_next   = (in == COIN_INV) ||
                 (coin_valid && ((state == VEND) || (state == CHANGE) || cancel_ok));
    chg_start  = cancel_ok || ((state == VEND) && (remainder != '0));
    chg_amt    = (state == VEND) ? remainder : credit;
  end

  // FSM, credit register and the registered vend / reject pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every register, outputs included, clears on the asynchronous reset so the outputs drop without waiting for a clock edge.
      state    <= IDLE;
      credit   <= '0;
      out      <= 1'b0;
      coin_rej <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge credit and state.
      out      <= 1'b0;
      coin_rej <= rej_next;
      case (state)
        IDLE, COLLECT: begin
          if (cancel_ok) begin
            state <= CHANGE;
          end else if (coin_valid) begin
            credit <= sum;
            if (sum >= PRICE_C) begin
              state <= VEND;
              out   <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end
        VEND: begin
          credit <= remainder;
          state  <= (remainder != '0) ? CHANGE : IDLE;
        end
        CHANGE: begin
          if (chg_fire) begin
            credit <= credit - chg_coin_val;
          end
          if (chg_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  vm_change_unit #(
    .CREDIT_W (CREDIT_W),
    .COIN_A   (COIN_A),
    .COIN_B   (COIN_B)
  ) u_change (
    .clk        (clk),
    .rst        (rst),
    .start      (chg_start),
    .start_amt  (chg_amt),
    .remain     (credit),
    .change_rdy (change_rdy),
    .change_vld (change_vld),
    .change     (change),
    .fire       (chg_fire),
    .coin_val   (chg_coin_val),
    .done       (chg_done)
  );

endmodule
